imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder behind a two-entry elastic stage.
// Each accepted instruction word is decoded into its immediate, branch/jump
// target, format code and an illegal-opcode flag, then held in an output
// register backed by a one-entry skid buffer so in_ready can be registered.
// Optional feature macro: IMM_GEN_CSR_EN enables CSR immediate decoding
// (opcode 1110011). Without it that opcode is reported as illegal.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_Z  = 3'd6,
    FMT_SH = 3'd7
  } fmt_e;

  typedef struct packed {
    logic            illegal;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] imm;
  } entry_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;

  // Candidate immediates for every format; signed casts sign-extend to XLEN.
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_sh;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_z;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_sh = XLEN'(in_inst[20 +: SHAMT_W]);
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                 in_inst[11:8], 1'b0}));
  assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                 in_inst[30:21], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_z  = XLEN'(in_inst[19:15]);

  entry_t dec_entry;
  logic   dec_use_target;

  // Decode the incoming word into a complete output entry.
  always_comb begin
    dec_entry         = '0;
    dec_entry.fmt     = FMT_R;
    dec_use_target    = 1'b0;
    unique case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_entry.imm = imm_sh;
          dec_entry.fmt = FMT_SH;
        end else begin
          dec_entry.imm = imm_i;
          dec_entry.fmt = FMT_I;
        end
      end
      OP_LOAD, OP_JALR: begin
        dec_entry.imm = imm_i;
        dec_entry.fmt = FMT_I;
      end
      OP_STORE: begin
        dec_entry.imm = imm_s;
        dec_entry.fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec_entry.imm  = imm_b;
        dec_entry.fmt  = FMT_B;
        dec_use_target = 1'b1;
      end
      OP_JAL: begin
        dec_entry.imm  = imm_j;
        dec_entry.fmt  = FMT_J;
        dec_use_target = 1'b1;
      end
      OP_LUI: begin
        dec_entry.imm = imm_u;
        dec_entry.fmt = FMT_U;
      end
      OP_AUIPC: begin
        dec_entry.imm  = imm_u;
        dec_entry.fmt  = FMT_U;
        dec_use_target = 1'b1;
      end
      OP_REG: begin
        dec_entry.fmt = FMT_R;
      end
`ifdef IMM_GEN_CSR_EN
      OP_SYSTEM: begin
        // Only the immediate CSR forms (funct3 101/110/111) carry a uimm.
        if (funct3[2] && (funct3[1:0] != 2'b00)) begin
          dec_entry.imm = imm_z;
          dec_entry.fmt = FMT_Z;
        end
      end
`endif
      default: begin
        dec_entry.illegal = 1'b1;
      end
    endcase
    // Target wraps modulo 2^XLEN; non-PC-relative formats report zero.
    dec_entry.target = dec_use_target ? (in_pc + dec_entry.imm) : '0;
  end

`ifndef IMM_GEN_CSR_EN
  // The CSR immediate field is only consumed when CSR decoding is enabled;
  // OP_SYSTEM falls into the illegal default arm.
  logic unused_csr;
  assign unused_csr = ^{imm_z, OP_SYSTEM};
`endif

  entry_t out_entry_q, out_entry_d;
  entry_t skid_entry_q, skid_entry_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire;

  assign in_fire = in_valid && in_ready_q;

  // Elastic-stage next state: flush clears both slots, a held skid entry
  // drains into the output register, otherwise new beats fill output first.
  always_comb begin
    out_entry_d  = out_entry_q;
    skid_entry_d = skid_entry_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so no new beat can arrive this cycle.
      if (out_ready) begin
        out_entry_d  = skid_entry_q;
        skid_valid_d = 1'b0;
      end
    end else if (out_valid_q && !out_ready) begin
      // Output stalled: park the incoming beat so the output stays stable.
      if (in_fire) begin
        skid_entry_d = dec_entry;
        skid_valid_d = 1'b1;
      end
    end else begin
      // Output empty or being consumed: load straight into the output.
      out_valid_d = in_fire;
      if (in_fire) begin
        out_entry_d = dec_entry;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers with synchronous reset that wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_entry_q  <= '0;
      skid_entry_q <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_entry_q  <= out_entry_d;
      skid_entry_q <= skid_entry_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_entry_q.imm;
  assign out_target  = out_entry_q.target;
  assign out_fmt     = out_entry_q.fmt;
  assign out_illegal = out_entry_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: directed scenarios plus a randomized run
// checked against a queue-based reference model. A second instance with
// XLEN=64 covers the wide-datapath decoding.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_imm, out_target;
  logic [2:0]  out_fmt;

  logic        d64_in_valid, d64_in_ready, d64_out_valid, d64_out_illegal;
  logic [31:0] d64_in_inst;
  logic [63:0] d64_in_pc, d64_out_imm, d64_out_target;
  logic [2:0]  d64_out_fmt;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_target(out_target), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) u_dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(d64_in_valid), .in_ready(d64_in_ready), .in_inst(d64_in_inst),
    .in_pc(d64_in_pc), .out_valid(d64_out_valid), .out_ready(1'b1),
    .out_imm(d64_out_imm), .out_target(d64_out_target), .out_fmt(d64_out_fmt),
    .out_illegal(d64_out_illegal)
  );

  typedef struct {
    logic [31:0] imm;
    logic [31:0] target;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   cmp_count  = 0;
  int   fail_count = 0;

  // Two's-complement interpretation of a 'bits'-wide field value.
  function automatic logic [31:0] sext(input longint val, input int bits);
    longint v;
    v = val;
    if (v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  // Reference decoder: immediates assembled arithmetically from the fields.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t   e;
    longint f;
    logic [6:0] op;
    logic [2:0] f3;
    op = inst[6:0];
    f3 = inst[14:12];
    e.imm = 32'd0; e.target = 32'd0; e.fmt = 3'd0; e.ill = 1'b0;
    case (op)
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = 32'(inst[24:20]); e.fmt = 3'd7;
        end else begin
          e.imm = sext(longint'(inst[31:20]), 12); e.fmt = 3'd1;
        end
      end
      7'h03, 7'h67: begin
        e.imm = sext(longint'(inst[31:20]), 12); e.fmt = 3'd1;
      end
      7'h23: begin
        f = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
        e.imm = sext(f, 12); e.fmt = 3'd2;
      end
      7'h63: begin
        f = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
          + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
        e.imm = sext(f, 13); e.fmt = 3'd3; e.target = pc + e.imm;
      end
      7'h6F: begin
        f = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
          + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
        e.imm = sext(f, 21); e.fmt = 3'd5; e.target = pc + e.imm;
      end
      7'h37: begin
        e.imm = inst & 32'hFFFF_F000; e.fmt = 3'd4;
      end
      7'h17: begin
        e.imm = inst & 32'hFFFF_F000; e.fmt = 3'd4; e.target = pc + e.imm;
      end
      7'h33: begin
        e.fmt = 3'd0;
      end
`ifdef IMM_GEN_CSR_EN
      7'h73: begin
        if (f3 >= 3'd5) begin
          e.imm = 32'(inst[19:15]); e.fmt = 3'd6;
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one cycle of stimulus and advance the model by one clock.
  task automatic tick(input logic r, input logic v, input logic [31:0] inst,
                      input logic [31:0] pc, input logic ordy, input logic fl);
    int n;
    rst = r; in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    n = q.size();
    if (r || fl) begin
      q.delete();
    end else begin
      if (n > 0 && ordy) void'(q.pop_front());
      if (v && n < 2) q.push_back(ref_decode(inst, pc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 32'h0050_0093, 32'd0, 1'b0, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b0) begin fail_count++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    cmp_count++;
    if (out_imm !== 32'd0 || out_target !== 32'd0 || out_fmt !== 3'd0 || out_illegal !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_fields: got imm=%h tgt=%h fmt=%0d ill=%b expected all zero",
               out_imm, out_target, out_fmt, out_illegal);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cmp_count++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_addi();
    tick(1'b0, 1'b1, 32'hFFF0_0093, 32'h100, 1'b1, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFF_FFFF || out_fmt !== 3'd1 ||
        out_target !== 32'd0 || out_illegal !== 1'b0) begin
      fail_count++;
      $display("FAIL addi: got v=%b imm=%h fmt=%0d tgt=%h ill=%b expected 1 ffffffff 1 0 0",
               out_valid, out_imm, out_fmt, out_target, out_illegal);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b0) begin fail_count++; $display("FAIL addi_drained: got out_valid=%b expected 0", out_valid); end
    $display("test_addi: imm=%h fmt=%0d", 32'hFFFF_FFFF, 1);
  endtask

  task automatic test_beq();
    // Bit 7 of this encoding is set and supplies imm[11], so the offset is -4
    // and the target wraps below address zero.
    tick(1'b0, 1'b1, 32'hFE00_0EE3, 32'h0, 1'b1, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFF_FFFC || out_target !== 32'hFFFF_FFFC ||
        out_fmt !== 3'd3 || out_illegal !== 1'b0) begin
      fail_count++;
      $display("FAIL beq: got v=%b imm=%h tgt=%h fmt=%0d expected 1 fffffffc fffffffc 3",
               out_valid, out_imm, out_target, out_fmt);
    end
    // JAL backwards from a small pc also wraps.
    tick(1'b0, 1'b1, 32'hFF9F_F06F, 32'h4, 1'b1, 1'b0);
    cmp_count++;
    if (out_imm !== 32'hFFFF_FFF8 || out_target !== 32'hFFFF_FFFC || out_fmt !== 3'd5) begin
      fail_count++;
      $display("FAIL jal: got imm=%h tgt=%h fmt=%0d expected fffffff8 fffffffc 5",
               out_imm, out_target, out_fmt);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    $display("test_beq done");
  endtask

  task automatic test_back_to_back_stall();
    // A: addi imm 5; B: sw imm -4; C: lui 0x12345 (never accepted).
    tick(1'b0, 1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b1 || out_imm !== 32'd5 || in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL stall_c1: got v=%b imm=%h rdy=%b expected 1 5 1", out_valid, out_imm, in_ready);
    end
    tick(1'b0, 1'b1, 32'hFE11_2E23, 32'h0, 1'b0, 1'b0);
    cmp_count++;
    if (out_imm !== 32'd5 || out_fmt !== 3'd1 || in_ready !== 1'b0) begin
      fail_count++;
      $display("FAIL stall_c2: got imm=%h fmt=%0d rdy=%b expected 5 1 0", out_imm, out_fmt, in_ready);
    end
    tick(1'b0, 1'b1, 32'h1234_5037, 32'h0, 1'b0, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b1 || out_imm !== 32'd5 || out_fmt !== 3'd1 || in_ready !== 1'b0) begin
      fail_count++;
      $display("FAIL stall_c3: got v=%b imm=%h fmt=%0d rdy=%b expected 1 5 1 0",
               out_valid, out_imm, out_fmt, in_ready);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFF_FFFC || out_fmt !== 3'd2 || in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL stall_drain: got v=%b imm=%h fmt=%0d rdy=%b expected 1 fffffffc 2 1",
               out_valid, out_imm, out_fmt, in_ready);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b0) begin fail_count++; $display("FAIL stall_empty: got out_valid=%b expected 0", out_valid); end
    $display("test_back_to_back_stall done");
  endtask

  task automatic test_flush();
    tick(1'b0, 1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 32'hFE11_2E23, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 32'h1234_5037, 32'h0, 1'b1, 1'b1);
    cmp_count++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL flush: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cmp_count++;
    if (out_valid !== 1'b0) begin fail_count++; $display("FAIL flush_no_accept: got out_valid=%b expected 0", out_valid); end
    $display("test_flush done");
  endtask

  task automatic test_reset_midstall();
    tick(1'b0, 1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 32'hFE11_2E23, 32'h0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 32'h1234_5037, 32'h0, 1'b0, 1'b1);
    cmp_count++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'd0 || out_fmt !== 3'd0) begin
      fail_count++;
      $display("FAIL reset_midstall: got v=%b rdy=%b imm=%h fmt=%0d expected 0 1 0 0",
               out_valid, in_ready, out_imm, out_fmt);
    end
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    $display("test_reset_midstall done");
  endtask

  task automatic test_csr();
    tick(1'b0, 1'b1, 32'h3401_D073, 32'h0, 1'b1, 1'b0);
    cmp_count++;
`ifdef IMM_GEN_CSR_EN
    if (out_valid !== 1'b1 || out_imm !== 32'd3 || out_fmt !== 3'd6 || out_illegal !== 1'b0) begin
      fail_count++;
      $display("FAIL csrrwi: got v=%b imm=%h fmt=%0d ill=%b expected 1 3 6 0",
               out_valid, out_imm, out_fmt, out_illegal);
    end
`else
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_imm !== 32'd0 || out_fmt !== 3'd0 ||
        out_target !== 32'd0) begin
      fail_count++;
      $display("FAIL csrrwi: got v=%b ill=%b imm=%h fmt=%0d tgt=%h expected 1 1 0 0 0",
               out_valid, out_illegal, out_imm, out_fmt, out_target);
    end
`endif
    tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    $display("test_csr done");
  endtask

  task automatic test_xlen64();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    d64_in_valid = 1'b1; d64_in_inst = 32'h03F0_9093; d64_in_pc = 64'h1000;
    @(posedge clk); #1;
    cmp_count++;
    if (d64_out_valid !== 1'b1 || d64_out_imm !== 64'd63 || d64_out_fmt !== 3'd7) begin
      fail_count++;
      $display("FAIL x64_slli: got v=%b imm=%h fmt=%0d expected 1 3f 7",
               d64_out_valid, d64_out_imm, d64_out_fmt);
    end
    d64_in_inst = 32'h8000_00B7;
    @(posedge clk); #1;
    cmp_count++;
    if (d64_out_imm !== 64'hFFFF_FFFF_8000_0000 || d64_out_fmt !== 3'd4 || d64_out_target !== 64'd0) begin
      fail_count++;
      $display("FAIL x64_lui: got imm=%h fmt=%0d tgt=%h expected ffffffff80000000 4 0",
               d64_out_imm, d64_out_fmt, d64_out_target);
    end
    d64_in_valid = 1'b0;
    @(posedge clk); #1;
    $display("test_xlen64 done");
  endtask

  task automatic test_random();
    logic [6:0]  ops[10];
    logic [31:0] r, inst, pc;
    logic        v, ordy, fl;
    int          xfers;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h73};
    xfers = 0;
    for (int i = 0; i < 400; i++) begin
      int idx;
      r    = $urandom();
      idx  = $urandom_range(0, 10);
      inst = (idx == 10) ? r : {r[31:7], ops[idx]};
      pc   = $urandom();
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 39) == 0);
      if (q.size() > 0 && ordy && !fl) begin
        xfers++;
        $display("xfer %0d imm=%h tgt=%h fmt=%0d ill=%b", xfers, q[0].imm, q[0].target, q[0].fmt, q[0].ill);
      end
      tick(1'b0, v, inst, pc, ordy, fl);
      cmp_count++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        fail_count++;
        $display("FAIL rand_hs[%0d]: got v=%b rdy=%b expected v=%b rdy=%b",
                 i, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        cmp_count++;
        if (out_imm !== q[0].imm || out_target !== q[0].target ||
            out_fmt !== q[0].fmt || out_illegal !== q[0].ill) begin
          fail_count++;
          $display("FAIL rand_data[%0d]: got imm=%h tgt=%h fmt=%0d ill=%b expected imm=%h tgt=%h fmt=%0d ill=%b",
                   i, out_imm, out_target, out_fmt, out_illegal,
                   q[0].imm, q[0].target, q[0].fmt, q[0].ill);
        end
      end
    end
    $display("test_random done: %0d transfers", xfers);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
    d64_in_valid = 1'b0; d64_in_inst = 32'd0; d64_in_pc = 64'd0;
    test_reset();
    test_addi();
    test_beq();
    test_back_to_back_stall();
    test_flush();
    test_reset_midstall();
    test_csr();
    test_xlen64();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
